vpu_vec_mem_responder: RTL and testbench
========================================

// Module: vpu_vec_mem_responder
// PURPOSE
//  Memory-side responder for the VPU vector-operand protocol. Serves two burst read ports:
//  A (operand A) and B (operand B or the single-word constant). Serves one burst write port:
//  C (result vector). Backed by a DEPTH-word flop scratchpad.
//  Sits between the VPU and the unified buffer. Each vector transfer is M words.
// PARAMETERS
//  DATA_W  32    word width
//  ADDR_W  16    request address width; only low $clog2(DEPTH) bits index storage
//  M       4     words per vector burst
//  DEPTH   1024  scratchpad words (power of two)
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset, asynchronous, active-high
//  rd_a_valid    in   1       port A burst request
//  rd_a_ready    out  1       port A idle, can accept a request
//  rd_a_addr     in   ADDR_W  port A burst base word address
//  rd_a_rvalid   out  1       port A response beat valid
//  rd_a_rdata    out  DATA_W  port A response word
//  rd_b_valid    in   1       port B burst request
//  rd_b_ready    out  1       port B idle, can accept a request
//  rd_b_addr     in   ADDR_W  port B base address
//  rd_b_single   in   1       sampled with request: 1 = 1-beat (constant) read, 0 = M beats
//  rd_b_rvalid   out  1       port B response beat valid
//  rd_b_rdata    out  DATA_W  port B response word
//  wr_valid      in   1       write beat valid
//  wr_ready      out  1       write beat accepted (constant 1 outside reset)
//  wr_addr       in   ADDR_W  burst base address, sampled on beat 0 only
//  wr_data       in   DATA_W  write word
//  wr_done       out  1       1-cycle pulse after the M-th beat is written
// BEHAVIOUR
//  Reset:
//   - rd_*_ready=0 while rst is high, 1 after; *_rvalid=0, *_rdata=0, wr_done=0.
//   - Port FSMs go to IDLE; beat counters are set to 0.
//   - Storage contents are not reset.
//  Read port FSM (per port):
//   - IDLE: ready=1. valid&ready accepts the request. Latch base=addr[IDX-1:0].
//     Latch len=(single ? 1 : M). Go to BURST.
//   - BURST: ready=0. Output one beat per cycle with no gaps. Beat k has rvalid=1 and
//     rdata=mem[(base+k) mod DEPTH], for k=0..len-1.
//   - Leave BURST after beat len-1. In that cycle ready is still 0; IDLE starts the next cycle.
//  Read latency:
//   - Beat 0 appears the cycle after acceptance; rdata is registered.
//   - No response backpressure: the requester must take every beat.
//  Port A ignores rd_b_single; its len is always M.
//  Requests while ready=0 are ignored. The requester holds valid until ready.
//  Write port:
//   - wr_ready=1 always (0 in reset). Each wr_valid cycle is one beat; gaps are allowed.
//   - Beat 0 (beat counter=0) latches base from wr_addr.
//   - Beat k writes mem[(base+k) mod DEPTH]=wr_data at the clock edge.
//   - After beat M-1 the counter returns to 0, and wr_done pulses the next cycle.
//  Address wrap:
//   - The index is (base+k) mod DEPTH. ADDR_W bits above $clog2(DEPTH) are ignored.
//  Simultaneous read and write of the same word in one cycle is read-before-write: the read
//   returns old data. The write is visible from the next cycle.
//  A and B may read the same word at the same time; both get identical data.
//  Reset mid-burst aborts the burst. No further rvalid beats are produced, and a partial
//   write burst is abandoned. Words already written stay written.
// STRUCTURE
//  Shared package vpu_pkg:
//   - DATA_W, ADDR_W, M constants.
//   - typedef enum logic {RD_IDLE, RD_BURST} rd_state_t.
//  Sub-module vpu_mem_rd_port:
//   - Holds the read FSM, base/len latches, and the beat counter $clog2(M+1) bits wide.
//   - Drives the storage read index. Instantiated twice (A, B). Port A ties single=0.
//  The top level holds the storage array, the write beat counter/base latch, and wr_done.
// TESTING
//  1. Write burst base=8, data 1,2,3,4.
//     -> wr_done 1 cycle after beat 3.
//     Then port A read addr=8 -> rvalid 4 consecutive cycles starting 1 cycle after accept,
//     rdata 1,2,3,4.
//  2. Port B single=1 addr=9 -> exactly 1 beat with rdata=2, then rd_b_ready=1 the
//     following cycle.
//  3. Write base=DEPTH-2 with data A,B,C,D. Read addr=DEPTH-2 -> A,B,C,D.
//     mem[0]=C and mem[1]=D, confirming the wrap.
//  4. Port A reads addr 8 while the write burst writes 0xFF to addr 8 in the same cycle
//     as A's beat-0 read.
//     -> beat 0 returns 1 (old data). A re-read returns 0xFF.
//  5. Assert rd_a_valid while A is in BURST -> ignored, ready stays 0, only 4 beats return.
//     A and B both read addr 8 concurrently -> identical data.
//  6. Assert rst mid read burst (after beat 1) -> rvalid drops immediately, ready=0 during
//     reset, IDLE after. Assert rst after 2 write beats -> wr_done never pulses, and
//     already-written words persist.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared constants and types for the VPU vector-operand memory responder.
package vpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int M      = 4;
  localparam int DEPTH  = 1024;

  typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;
endpackage

// File: rtl/vpu_mem_rd_port.sv
// One burst read port: accepts a request, then streams 1 or M registered words
// from the scratchpad with no gaps.
module vpu_mem_rd_port #(
  parameter int DATA_W = vpu_pkg::DATA_W,
  parameter int ADDR_W = vpu_pkg::ADDR_W,
  parameter int M      = vpu_pkg::M,
  parameter int DEPTH  = vpu_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic                     i_single,
  output logic                     o_ready,
  output logic                     o_rvalid,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [$clog2(DEPTH)-1:0] o_idx,
  input  logic [DATA_W-1:0]        i_word
);
  import vpu_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(M + 1);

  rd_state_t          r_state;
  logic               r_ready;
  logic               r_rvalid;
  logic [DATA_W-1:0]  r_rdata;
  logic [IDX_W-1:0]   r_base;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_len;
  logic               w_last;
  logic               w_unused_addr;

  assign o_ready       = r_ready;
  assign o_rvalid      = r_rvalid;
  assign o_rdata       = r_rdata;
  assign w_last        = (r_cnt == r_len - CNT_W'(1));
  assign w_unused_addr = ^i_addr[ADDR_W-1:IDX_W];

  // The word for the next beat is fetched one cycle early so rdata can be registered.
  always_comb begin
    o_idx = i_addr[IDX_W-1:0];
    if (r_state == RD_BURST) o_idx = r_base + IDX_W'(r_cnt) + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RD_IDLE;
      r_ready  <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_base   <= '0;
      r_cnt    <= '0;
      r_len    <= '0;
    end else begin
      case (r_state)
        RD_IDLE: begin
          r_ready  <= 1'b1;
          r_rvalid <= 1'b0;
          if (i_valid && r_ready) begin
            r_state  <= RD_BURST;
            r_ready  <= 1'b0;
            r_base   <= i_addr[IDX_W-1:0];
            r_len    <= i_single ? CNT_W'(1) : CNT_W'(M);
            r_cnt    <= '0;
            r_rvalid <= 1'b1;
            r_rdata  <= i_word;
          end
        end
        RD_BURST: begin
          if (w_last) begin
            r_state  <= RD_IDLE;
            r_ready  <= 1'b1;
            r_rvalid <= 1'b0;
            r_cnt    <= '0;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_rdata <= i_word;
          end
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/vpu_vec_mem_responder.sv
// Scratchpad responder for the VPU: two burst read ports (A, B) and one burst
// write port (C), all backed by a DEPTH-word flop array.
module vpu_vec_mem_responder #(
  parameter int DATA_W = vpu_pkg::DATA_W,
  parameter int ADDR_W = vpu_pkg::ADDR_W,
  parameter int M      = vpu_pkg::M,
  parameter int DEPTH  = vpu_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_a_valid,
  output logic              rd_a_ready,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic              rd_a_rvalid,
  output logic [DATA_W-1:0] rd_a_rdata,
  input  logic              rd_b_valid,
  output logic              rd_b_ready,
  input  logic [ADDR_W-1:0] rd_b_addr,
  input  logic              rd_b_single,
  output logic              rd_b_rvalid,
  output logic [DATA_W-1:0] rd_b_rdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done
);
  import vpu_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(M + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]  r_wbase;
  logic [CNT_W-1:0]  r_wcnt;
  logic              r_wr_done;
  logic [IDX_W-1:0]  w_a_idx;
  logic [IDX_W-1:0]  w_b_idx;
  logic [IDX_W-1:0]  w_widx;
  logic              w_wr_en;
  logic              w_unused_waddr;

  assign wr_ready       = ~rst;
  assign wr_done        = r_wr_done;
  assign w_wr_en        = wr_valid & ~rst;
  assign w_widx         = (r_wcnt == '0) ? wr_addr[IDX_W-1:0] : r_wbase + IDX_W'(r_wcnt);
  assign w_unused_waddr = ^wr_addr[ADDR_W-1:IDX_W];

  vpu_mem_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .M(M), .DEPTH(DEPTH)) u_rd_a (
    .clk(clk), .rst(rst), .i_valid(rd_a_valid), .i_addr(rd_a_addr), .i_single(1'b0),
    .o_ready(rd_a_ready), .o_rvalid(rd_a_rvalid), .o_rdata(rd_a_rdata),
    .o_idx(w_a_idx), .i_word(r_mem[w_a_idx])
  );

  vpu_mem_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .M(M), .DEPTH(DEPTH)) u_rd_b (
    .clk(clk), .rst(rst), .i_valid(rd_b_valid), .i_addr(rd_b_addr), .i_single(rd_b_single),
    .o_ready(rd_b_ready), .o_rvalid(rd_b_rvalid), .o_rdata(rd_b_rdata),
    .o_idx(w_b_idx), .i_word(r_mem[w_b_idx])
  );

  // Storage and the burst base are never reset; reads sample old contents at the same edge.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_widx] <= wr_data;
      if (r_wcnt == '0) r_wbase <= w_widx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt    <= '0;
      r_wr_done <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      if (wr_valid) begin
        if (r_wcnt == CNT_W'(M - 1)) begin
          r_wcnt    <= '0;
          r_wr_done <= 1'b1;
        end else begin
          r_wcnt <= r_wcnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_vpu_vec_mem_responder.sv
// Scoreboard bench for vpu_vec_mem_responder: stimulus pushes expected read beats,
// a negedge monitor pops and compares them.
module tb_vpu_vec_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        rd_a_valid, rd_a_ready, rd_a_rvalid;
  logic [15:0] rd_a_addr;
  logic [31:0] rd_a_rdata;
  logic        rd_b_valid, rd_b_ready, rd_b_single, rd_b_rvalid;
  logic [15:0] rd_b_addr;
  logic [31:0] rd_b_rdata;
  logic        wr_valid, wr_ready, wr_done;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  vpu_vec_mem_responder dut (
    .clk(clk), .rst(rst),
    .rd_a_valid(rd_a_valid), .rd_a_ready(rd_a_ready), .rd_a_addr(rd_a_addr),
    .rd_a_rvalid(rd_a_rvalid), .rd_a_rdata(rd_a_rdata),
    .rd_b_valid(rd_b_valid), .rd_b_ready(rd_b_ready), .rd_b_addr(rd_b_addr),
    .rd_b_single(rd_b_single), .rd_b_rvalid(rd_b_rvalid), .rd_b_rdata(rd_b_rdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every presented beat must match the next expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_a_rvalid) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_extra_beat got %h want none", rd_a_rdata);
        end else chk("a_rdata", rd_a_rdata, qa.pop_front());
      end
      if (rd_b_rvalid) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_extra_beat got %h want none", rd_b_rdata);
        end else chk("b_rdata", rd_b_rdata, qb.pop_front());
      end
      if (wr_done) done_cnt++;
    end
  end

  task automatic wait_rdy(input bit is_b);
    int n = 0;
    while ((is_b ? rd_b_ready : rd_a_ready) !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL ready_timeout got 0 want 1 port_b=%0d", is_b);
    end
  endtask

  task automatic issue_a(input logic [15:0] addr, input int n,
                         input logic [31:0] e0, e1, e2, e3);
    logic [31:0] e [4];
    e = '{e0, e1, e2, e3};
    wait_rdy(1'b0);
    rd_a_valid = 1'b1;
    rd_a_addr  = addr;
    for (int i = 0; i < n; i++) qa.push_back(e[i]);
    @(posedge clk); #1;
    rd_a_valid = 1'b0;
  endtask

  task automatic issue_b(input logic [15:0] addr, input bit single,
                         input logic [31:0] e0, e1, e2, e3);
    logic [31:0] e [4];
    e = '{e0, e1, e2, e3};
    wait_rdy(1'b1);
    rd_b_valid  = 1'b1;
    rd_b_addr   = addr;
    rd_b_single = single;
    for (int i = 0; i < (single ? 1 : 4); i++) qb.push_back(e[i]);
    @(posedge clk); #1;
    rd_b_valid = 1'b0;
  endtask

  // Beats 1..3 carry a junk address to show only beat 0's address is used.
  task automatic wr_burst(input logic [15:0] addr, input logic [31:0] d0, d1, d2, d3);
    logic [31:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1;
      wr_addr  = (k == 0) ? addr : 16'hDEAD;
      wr_data  = d[k];
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    exp_done++;
    chk("wr_done_pulse", {31'd0, wr_done}, 32'd1);
    @(posedge clk); #1;
    chk("wr_done_single", {31'd0, wr_done}, 32'd0);
  endtask

  task automatic drain();
    repeat (6) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1;
    rd_a_valid = 0; rd_a_addr = 0;
    rd_b_valid = 0; rd_b_addr = 0; rd_b_single = 0;
    wr_valid = 0; wr_addr = 0; wr_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", {31'd0, rd_a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, rd_b_ready}, 32'd0);
    chk("rst_rvalid", {30'd0, rd_a_rvalid, rd_b_rvalid}, 32'd0);
    chk("rst_rdata", rd_a_rdata | rd_b_rdata, 32'd0);
    chk("rst_wr", {30'd0, wr_ready, wr_done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", {30'd0, rd_a_ready, rd_b_ready}, 32'd3);
    chk("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);

    // Test 1: write then 4 consecutive beats from A
    wr_burst(16'd8, 32'd1, 32'd2, 32'd3, 32'd4);
    issue_a(16'd8, 4, 32'd1, 32'd2, 32'd3, 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("a_beat_valid", {31'd0, rd_a_rvalid}, 32'd1);
      chk("a_burst_ready", {31'd0, rd_a_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("a_end_rvalid", {31'd0, rd_a_rvalid}, 32'd0);
    chk("a_end_ready", {31'd0, rd_a_ready}, 32'd1);

    // Test 2: single-beat read on B
    issue_b(16'd9, 1'b1, 32'd2, 32'd0, 32'd0, 32'd0);
    chk("b_single_valid", {31'd0, rd_b_rvalid}, 32'd1);
    chk("b_single_ready", {31'd0, rd_b_ready}, 32'd0);
    @(posedge clk); #1;
    chk("b_single_end_valid", {31'd0, rd_b_rvalid}, 32'd0);
    chk("b_single_end_ready", {31'd0, rd_b_ready}, 32'd1);

    // Test 3: wrap at the top of the scratchpad, high address bits ignored
    wr_burst(16'd1022, 32'hA0, 32'hB0, 32'hC0, 32'hD0);
    issue_a(16'd1022, 4, 32'hA0, 32'hB0, 32'hC0, 32'hD0);
    drain();
    issue_b(16'd0, 1'b1, 32'hC0, 32'd0, 32'd0, 32'd0);
    issue_b(16'h0401, 1'b1, 32'hD0, 32'd0, 32'd0, 32'd0);
    drain();

    // Test 4: read-before-write on colliding addresses
    fork
      issue_a(16'd8, 4, 32'd1, 32'd2, 32'd3, 32'd4);
      wr_burst(16'd8, 32'hFF, 32'h22, 32'h33, 32'h44);
    join
    drain();
    issue_a(16'd8, 4, 32'hFF, 32'h22, 32'h33, 32'h44);
    drain();

    // Test 5: request held during a burst is ignored; concurrent A/B reads
    wait_rdy(1'b0);
    rd_a_valid = 1'b1; rd_a_addr = 16'd8;
    qa.push_back(32'hFF); qa.push_back(32'h22); qa.push_back(32'h33); qa.push_back(32'h44);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk("a_busy_ready", {31'd0, rd_a_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rd_a_valid = 1'b0;
    @(posedge clk); #1;
    chk("a_busy_end_rvalid", {31'd0, rd_a_rvalid}, 32'd0);
    drain();
    fork
      issue_a(16'd8, 4, 32'hFF, 32'h22, 32'h33, 32'h44);
      issue_b(16'd8, 1'b0, 32'hFF, 32'h22, 32'h33, 32'h44);
    join
    drain();

    // Test 6: reset during a read burst and during a write burst
    issue_a(16'd8, 2, 32'hFF, 32'h22, 32'd0, 32'd0);
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_rvalid", {31'd0, rd_a_rvalid}, 32'd0);
    chk("rst_mid_ready", {31'd0, rd_a_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_rel_ready", {31'd0, rd_a_ready}, 32'd1);
    chk("rst_rel_rvalid", {31'd0, rd_a_rvalid}, 32'd0);

    wr_valid = 1'b1; wr_addr = 16'd100; wr_data = 32'h5;
    @(posedge clk); #1;
    wr_addr = 16'hDEAD; wr_data = 32'h6;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {31'd0, wr_done}, 32'd0);
    end
    wr_burst(16'd200, 32'h7, 32'h8, 32'h9, 32'hA);
    issue_b(16'd100, 1'b1, 32'h5, 32'd0, 32'd0, 32'd0);
    issue_b(16'd101, 1'b1, 32'h6, 32'd0, 32'd0, 32'd0);
    issue_a(16'd8, 4, 32'hFF, 32'h22, 32'h33, 32'h44);
    issue_b(16'd200, 1'b0, 32'h7, 32'h8, 32'h9, 32'hA);
    drain();

    chk("qa_empty", qa.size(), 32'd0);
    chk("qb_empty", qb.size(), 32'd0);
    chk("done_count", done_cnt, exp_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
